// File: rtl/fifo_uart_tx_if.sv
// Bundle between the upstream FIFO / control side and the UART transmitter.
// master drives en/empty/data and sees rd_en/tx/busy/sent; slave is the UART.
interface fifo_uart_tx_if;
  logic       en_i;
  logic       fifo_empty_i;
  logic [7:0] fifo_data_i;
  logic       fifo_rd_en_o;
  logic       tx_o;
  logic       busy_o;
  logic       sent_o;

  modport master (
    output en_i,
    output fifo_empty_i,
    output fifo_data_i,
    input  fifo_rd_en_o,
    input  tx_o,
    input  busy_o,
    input  sent_o
  );

  modport slave (
    input  en_i,
    input  fifo_empty_i,
    input  fifo_data_i,
    output fifo_rd_en_o,
    output tx_o,
    output busy_o,
    output sent_o
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining an upstream FIFO: 8 data bits, 1 or 2 stop bits.
// Ports: clk, rst (async active-high), bus (slave modport of fifo_uart_tx_if).
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1
) (
  input logic           clk,
  input logic           rst,
  fifo_uart_tx_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  sh_q, sh_d;
  logic        tx_q, tx_d;

  logic bit_end;
  logic frame_go;
  logic stop_end;

  assign bit_end  = (cnt_q == BIT_LAST);
  assign frame_go = bus.en_i && !bus.fifo_empty_i;
  // idx_q doubles as the stop-bit index so the
  // 16-bit counter never has to span two stop bits
  assign stop_end = (state_q == S_STOP) && bit_end
                    && (idx_q == STOP_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (frame_go) state_d = S_FETCH;
      end
      S_FETCH: begin
        cnt_d   = '0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        cnt_d   = '0;
        idx_d   = '0;
        sh_d    = bus.fifo_data_i;
        state_d = S_START;
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == STOP_LAST) begin
            idx_d   = '0;
            state_d = frame_go ? S_FETCH : S_IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Line level is computed from the next state so
  // the registered tx_q lines up with state_q
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = sh_d[idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

  assign bus.fifo_rd_en_o = (state_q == S_FETCH);
  assign bus.tx_o         = tx_q;
  assign bus.busy_o       = (state_q != S_IDLE);
  assign bus.sent_o       = stop_end;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: FIFO model, frame monitor, directed tests.
// dut0 runs 4 clks/bit with 1 stop bit, dut1 4 clks/bit with 2 stop bits.
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_uart_tx_if bus0 ();
  fifo_uart_tx_if bus1 ();

  fifo_uart_tx #(
    .CLKS_PER_BIT(4),
    .STOP_BITS   (1)
  ) u_dut0 (
    .clk(clk),
    .rst(rst),
    .bus(bus0)
  );

  fifo_uart_tx #(
    .CLKS_PER_BIT(4),
    .STOP_BITS   (2)
  ) u_dut1 (
    .clk(clk),
    .rst(rst),
    .bus(bus1)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] fq[$];
  logic [7:0] exq[$];
  int         gap_q[$];
  int         rd_cnt   = 0;
  int         sent_cnt = 0;
  int         rd1_cnt  = 0;
  logic       blk      = 1'b0;
  logic       want1    = 1'b0;
  logic       hold0    = 1'b0;
  logic       hold1    = 1'b0;

  logic        cap = 1'b0;
  int          k   = 0;
  int          idle_cnt = 0;
  logic [63:0] txv, sv;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic bit frame_ok(input logic [63:0] t,
                                  input logic [63:0] s,
                                  input int ns,
                                  output logic [7:0] d);
    bit   ok;
    int   len;
    logic v;
    ok  = 1'b1;
    d   = '0;
    len = (9 + ns) * 4;
    for (int b = 0; b < 9 + ns; b++) begin
      v = t[b*4];
      for (int j = 1; j < 4; j++)
        if (t[b*4+j] !== v) ok = 1'b0;
      if (b == 0 && v !== 1'b0) ok = 1'b0;
      if (b >= 1 && b <= 8) d[b-1] = v;
      if (b > 8 && v !== 1'b1) ok = 1'b0;
    end
    for (int i = 0; i < len; i++)
      if (s[i] !== (i == len - 1)) ok = 1'b0;
    return ok;
  endfunction

  // FIFO models, pulse counters and dut0 frame monitor
  always @(negedge clk) begin
    logic [7:0] d;
    bit         ok;
    if (bus0.fifo_rd_en_o) rd_cnt++;
    if (bus0.sent_o) sent_cnt++;
    if (bus0.fifo_rd_en_o) begin
      checks++;
      if (fq.size() == 0) begin
        failures++;
        $display("FAIL underflow rd_en with empty fifo");
        bus0.fifo_data_i = 8'hxx;
      end else begin
        bus0.fifo_data_i = fq.pop_front();
      end
      hold0 = 1'b1;
    end else if (hold0) begin
      hold0 = 1'b0;
    end else begin
      bus0.fifo_data_i = 8'($urandom);
    end
    bus0.fifo_empty_i = (fq.size() == 0) || blk;

    if (bus1.fifo_rd_en_o) begin
      rd1_cnt++;
      bus1.fifo_data_i = 8'h81;
      hold1 = 1'b1;
    end else if (hold1) begin
      hold1 = 1'b0;
    end else begin
      bus1.fifo_data_i = 8'($urandom);
    end
    bus1.fifo_empty_i = !want1;

    if (rst) begin
      cap      = 1'b0;
      idle_cnt = 0;
    end else if (!cap) begin
      if (bus0.tx_o === 1'b0) begin
        gap_q.push_back(idle_cnt);
        idle_cnt = 0;
        cap      = 1'b1;
        txv      = '0;
        sv       = '0;
        txv[0]   = bus0.tx_o;
        sv[0]    = bus0.sent_o;
        k        = 1;
      end else begin
        idle_cnt++;
      end
    end else begin
      txv[k] = bus0.tx_o;
      sv[k]  = bus0.sent_o;
      k++;
      if (k == 40) begin
        cap = 1'b0;
        ok  = frame_ok(txv, sv, 1, d);
        chk("frame_fmt", 32'(ok), 32'd1);
        checks++;
        if (exq.size() == 0) begin
          failures++;
          $display("FAIL frame_data actual=%0h required=none", d);
        end else begin
          logic [7:0] e;
          e = exq.pop_front();
          if (d !== e) begin
            failures++;
            $display("FAIL frame_data actual=%0h required=%0h", d, e);
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    exq.push_back(b);
  endtask

  task automatic wait_sent(input int target, input int budget);
    int n;
    n = 0;
    while (sent_cnt < target && n < budget) begin
      step();
      n++;
    end
    if (sent_cnt < target) begin
      checks++;
      failures++;
      $display("FAIL wait_sent actual=%0d required=%0d", sent_cnt, target);
    end
  endtask

  task automatic wait_tx_low(input int budget);
    int n;
    n = 0;
    while (bus0.tx_o !== 1'b0 && n < budget) begin
      step();
      n++;
    end
    if (bus0.tx_o !== 1'b0) begin
      checks++;
      failures++;
      $display("FAIL wait_tx_low actual=%b required=0", bus0.tx_o);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, s0, g0, lows, n, r1;
    logic [63:0] t1, s1;
    logic [7:0]  d1;
    bit          ok1;
    rst          = 1'b1;
    bus0.en_i    = 1'b0;
    bus1.en_i    = 1'b1;
    repeat (3) step();
    chk("rst_tx", 32'(bus0.tx_o), 32'd1);
    chk("rst_busy", 32'(bus0.busy_o), 32'd0);
    chk("rst_rd", 32'(bus0.fifo_rd_en_o), 32'd0);
    chk("rst_sent", 32'(bus0.sent_o), 32'd0);
    rst = 1'b0;
    step();

    // single byte
    bus0.en_i = 1'b1;
    r0 = rd_cnt;
    s0 = sent_cnt;
    push(8'hA5);
    wait_sent(s0 + 1, 100);
    repeat (4) step();
    chk("t1_rd", 32'(rd_cnt - r0), 32'd1);
    chk("t1_sent", 32'(sent_cnt - s0), 32'd1);
    chk("t1_busy", 32'(bus0.busy_o), 32'd0);

    // back-to-back frames
    r0 = rd_cnt;
    s0 = sent_cnt;
    g0 = gap_q.size();
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    wait_sent(s0 + 3, 200);
    repeat (4) step();
    chk("t2_rd", 32'(rd_cnt - r0), 32'd3);
    chk("t2_frames", 32'(gap_q.size() - g0), 32'd3);
    if (gap_q.size() >= g0 + 3) begin
      chk("t2_gap1", 32'(gap_q[g0+1]), 32'd2);
      chk("t2_gap2", 32'(gap_q[g0+2]), 32'd2);
    end

    // enable low blocks new frames
    bus0.en_i = 1'b0;
    r0   = rd_cnt;
    lows = 0;
    push(8'h55);
    repeat (30) begin
      step();
      if (bus0.tx_o !== 1'b1) lows++;
    end
    chk("t3_no_rd", 32'(rd_cnt - r0), 32'd0);
    chk("t3_tx_low_cycles", 32'(lows), 32'd0);
    bus0.en_i = 1'b1;
    s0 = sent_cnt;
    wait_sent(s0 + 1, 100);

    // enable dropped during data bit 3
    repeat (3) step();
    r0 = rd_cnt;
    s0 = sent_cnt;
    push(8'h96);
    push(8'h5A);
    wait_tx_low(50);
    repeat (17) step();
    bus0.en_i = 1'b0;
    wait_sent(s0 + 1, 100);
    repeat (40) step();
    chk("t3b_rd", 32'(rd_cnt - r0), 32'd1);
    chk("t3b_sent", 32'(sent_cnt - s0), 32'd1);
    chk("t3b_busy", 32'(bus0.busy_o), 32'd0);
    chk("t3b_tx", 32'(bus0.tx_o), 32'd1);
    bus0.en_i = 1'b1;
    wait_sent(s0 + 2, 100);

    // reset during data bit 5
    repeat (3) step();
    s0 = sent_cnt;
    push(8'h0F);
    push(8'h77);
    wait_tx_low(50);
    repeat (25) step();
    chk("t4_tx_pre", 32'(bus0.tx_o), 32'd0);
    rst = 1'b1;
    #1;
    chk("t4_tx_async", 32'(bus0.tx_o), 32'd1);
    chk("t4_busy_async", 32'(bus0.busy_o), 32'd0);
    void'(exq.pop_front());
    repeat (2) step();
    rst = 1'b0;
    wait_sent(s0 + 1, 100);
    repeat (3) step();

    // empty flag toggling while busy
    r0 = rd_cnt;
    s0 = sent_cnt;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    n = 0;
    while (sent_cnt < s0 + 3 && n < 400) begin
      blk = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    blk = 1'b0;
    repeat (4) step();
    chk("t5_rd", 32'(rd_cnt - r0), 32'd3);
    chk("t5_sent", 32'(sent_cnt - s0), 32'd3);

    // two stop bits on dut1
    r1    = rd1_cnt;
    want1 = 1'b1;
    n     = 0;
    while (rd1_cnt == r1 && n < 10) begin
      step();
      n++;
    end
    want1 = 1'b0;
    n     = 0;
    while (bus1.tx_o !== 1'b0 && n < 10) begin
      step();
      n++;
    end
    chk("t6_start", 32'(bus1.tx_o), 32'd0);
    t1 = '0;
    s1 = '0;
    for (int i = 0; i < 44; i++) begin
      if (i > 0) step();
      t1[i] = bus1.tx_o;
      s1[i] = bus1.sent_o;
    end
    ok1 = frame_ok(t1, s1, 2, d1);
    chk("t6_fmt", 32'(ok1), 32'd1);
    chk("t6_data", 32'(d1), 32'h81);
    step();
    chk("t6_tx_idle", 32'(bus1.tx_o), 32'd1);
    chk("t6_rd", 32'(rd1_cnt - r1), 32'd1);

    repeat (5) step();
    chk("sb_empty", 32'(exq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
